mesi_array_ctrl: RTL and testbench
==================================

MESI_ARRAY_CTRL -- requirements
Module: mesi_array_ctrl

Interface
REQ-001 Parameter SETS, default 16, number of sets; SHALL be a power of two and at least 2.
REQ-002 Parameter WAYS, default 4, ways per set; SHALL be a power of two and at least 2.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rstb  input  1  reset, asynchronous and active-low.
REQ-005 req_valid  input  1  request strobe; req_ready  output  1  block can accept a request this cycle.
REQ-006 req_cmd  input  3  0 NOP, 1 RD_L1, 2 WR_L1, 3 SNP_RD, 4 SNP_WR, 5 SNP_RWIM, 6 SNP_INV, 7 CLEAR.
REQ-007 req_set  input  log2(SETS)  set index; req_way  input  log2(WAYS)  way index (hit way, or victim way on a miss).
REQ-008 req_hit  input  1  tag match for req_set/req_way; C_in  input  1  high = another cache holds the line (sampled with the request).
REQ-009 resp_valid  output  1  one-cycle response strobe; state_out  output  2  line state after update (I=00, S=01, E=10, M=11).
REQ-010 bus_op  output  3  0 NULL, 1 READ, 2 WRITE, 3 INVALIDATE, 4 RWIM; l1_msg  output  3  0 NULLMsg, 1 GETLINE, 2 SENDLINE, 3 INVALIDATELINE, 4 EVICTLINE.
REQ-011 snoop_res  output  2  0 NOHIT, 1 HIT, 2 HITM; C_out  output  1  high when snoop_res is HIT or HITM.

Function
REQ-012 The block SHALL hold a SETS x WAYS array of 2-bit MESI states; a request is accepted when req_valid and req_ready are both high.
REQ-013 Control FSM states: IDLE, RESP, WB2, CLR; req_ready SHALL be high only in IDLE and RESP.
REQ-014 Latency: accepted request -> resp_valid exactly 1 cycle later; back-to-back requests SHALL be accepted every cycle.
REQ-015 A request SHALL see all array updates from the immediately preceding accepted request (same set/way included).
REQ-016 When req_hit=0, the addressed line SHALL be treated as I for the lookup, and its stored state serves only as the victim state.
REQ-017 RD_L1 on a hit (S/E/M): state unchanged, bus NULL, l1 SENDLINE.
REQ-018 RD_L1 on a miss: new state S if C_in=1, else E; bus READ; l1 SENDLINE.
REQ-019 WR_L1 on a hit: M->M with bus NULL; E->M with bus NULL; S->M with bus INVALIDATE; l1 GETLINE in all three cases.
REQ-020 WR_L1 on a miss: new state M, bus RWIM, l1 GETLINE.
REQ-021 Dirty victim on a local miss (req_hit=0, victim state M): first response beat bus WRITE + l1 EVICTLINE with state_out=I; FSM -> WB2; second beat next cycle carries the REQ-018/020 result; req_ready low during WB2.
REQ-022 SNP_RD: M->S bus WRITE, l1 GETLINE, HITM; E->S and S->S bus NULL, l1 NULLMsg, HIT; I gives NOHIT.
REQ-023 SNP_RWIM: M->I bus WRITE, l1 EVICTLINE, HITM; E/S->I bus NULL, l1 INVALIDATELINE, HIT; I gives NOHIT.
REQ-024 SNP_INV: S->I, l1 INVALIDATELINE, HIT; E, M and I unchanged, NULL/NULLMsg, NOHIT.
REQ-025 SNP_WR: state unchanged, NULL/NULLMsg/NOHIT; local commands SHALL always give snoop_res NOHIT.
REQ-026 NOP: no response, no array change.
REQ-027 CLEAR: FSM -> CLR; one set (all ways) forced to I per cycle, index 0..SETS-1; req_ready low for SETS cycles; a single resp_valid pulse (NULL/NULLMsg/NOHIT, state_out=I) follows the last set.
REQ-028 When resp_valid=0, bus_op, l1_msg, snoop_res and C_out SHALL be zero; state_out SHALL hold its last value.

Reset
REQ-029 On rstb low, asynchronously: all array entries I, FSM IDLE, req_ready 1, resp_valid 0, bus_op NULL, l1_msg NULLMsg, snoop_res NOHIT, C_out 0, state_out I, clear counter 0.
REQ-030 Reset during CLR or WB2 SHALL abort the operation, with no pending response after release.

Verification
REQ-031 Set 3 way 1 in I: RD_L1 with req_hit=0, C_in=0 -> next cycle resp_valid, state_out E, bus READ, l1 SENDLINE; then WR_L1 with req_hit=1 -> state_out M, bus NULL, l1 GETLINE.
REQ-032 Line in M: SNP_RD with req_hit=1 -> state_out S, bus WRITE, l1 GETLINE, snoop_res HITM, C_out 1.
REQ-033 Victim in M: RD_L1 with req_hit=0, C_in=1 -> beat 1: WRITE/EVICTLINE/I; beat 2: READ/SENDLINE/S; req_ready low for one cycle.
REQ-034 CLEAR with SETS=16 -> req_ready low for 16 cycles, single resp pulse, all entries read back I; assert rstb at cycle 5 -> no response after release.
REQ-035 Line in S: back-to-back SNP_INV then WR_L1 (req_hit=0) on the same line -> INVALIDATELINE/HIT, then M/RWIM/GETLINE.

Source files
------------

// File: rtl/mesi_array_ctrl.sv
// mesi_array_ctrl: SETS x WAYS array of MESI line states with a small control FSM.
// Local (L1) requests and bus snoops are decoded against the addressed line. The result is
// registered, so each response appears exactly one cycle after the request is accepted.
// Ports:
//   clk, rstb                 clock, asynchronous active-low reset
//   req_valid/req_ready       request handshake
//   req_cmd, req_set, req_way request command and line address
//   req_hit, C_in             tag match, shared indication from other caches
//   resp_valid, state_out     response strobe, line state after the update
//   bus_op, l1_msg            bus action, message to the L1
//   snoop_res, C_out          snoop result, high on HIT/HITM
module mesi_array_ctrl #(
  parameter int unsigned SETS = 16,
  parameter int unsigned WAYS = 4
) (
  input  logic                      clk,
  input  logic                      rstb,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [2:0]                req_cmd,
  input  logic [$clog2(SETS)-1:0]   req_set,
  input  logic [$clog2(WAYS)-1:0]   req_way,
  input  logic                      req_hit,
  input  logic                      C_in,
  output logic                      resp_valid,
  output logic [1:0]                state_out,
  output logic [2:0]                bus_op,
  output logic [2:0]                l1_msg,
  output logic [1:0]                snoop_res,
  output logic                      C_out
);
  localparam int unsigned SW = $clog2(SETS);

  localparam logic [2:0] CmdNop = 3'd0, CmdRd = 3'd1, CmdWr = 3'd2, CmdSnpRd = 3'd3;
  localparam logic [2:0] CmdSnpWr = 3'd4, CmdSnpRwim = 3'd5, CmdSnpInv = 3'd6, CmdClear = 3'd7;
  localparam logic [1:0] MesiI = 2'd0, MesiS = 2'd1, MesiE = 2'd2, MesiM = 2'd3;
  localparam logic [2:0] BusNull = 3'd0, BusRead = 3'd1, BusWrite = 3'd2, BusInv = 3'd3;
  localparam logic [2:0] BusRwim = 3'd4;
  localparam logic [2:0] L1Null = 3'd0, L1Get = 3'd1, L1Send = 3'd2, L1Inv = 3'd3;
  localparam logic [2:0] L1Evict = 3'd4;
  localparam logic [1:0] SnpNoHit = 2'd0, SnpHit = 2'd1, SnpHitM = 2'd2;

  typedef enum logic [1:0] {StIdle, StResp, StWb2, StClr} state_t;

  state_t          state_q, state_d;
  logic [1:0]      mem_q [SETS][WAYS];
  logic [SW-1:0]   clr_q, clr_d;
  logic            resp_q, resp_d;
  logic [1:0]      st_out_q, st_out_d;
  logic [2:0]      bus_q, bus_d, l1_q, l1_d;
  logic [1:0]      snp_q, snp_d;
  // Second beat of a dirty-victim miss, captured at accept time.
  logic [1:0]      pend_st_q, pend_st_d;
  logic [2:0]      pend_bus_q, pend_bus_d, pend_l1_q, pend_l1_d;

  logic [1:0] stored, cur, new_st, new_snp;
  logic [2:0] new_bus, new_l1;
  logic       has_resp, local_cmd, accept, victim_dirty, mem_we;

  assign req_ready  = (state_q == StIdle) || (state_q == StResp);
  assign accept     = req_valid && req_ready;
  assign resp_valid = resp_q;
  assign state_out  = st_out_q;
  assign bus_op     = bus_q;
  assign l1_msg     = l1_q;
  assign snoop_res  = snp_q;
  assign C_out      = resp_q && (snp_q != SnpNoHit);

  // Protocol decode of the addressed line; a tag miss looks up as I.
  always_comb begin
    stored    = mem_q[req_set][req_way];
    cur       = req_hit ? stored : MesiI;
    new_st    = cur;
    new_bus   = BusNull;
    new_l1    = L1Null;
    new_snp   = SnpNoHit;
    has_resp  = 1'b1;
    local_cmd = 1'b0;
    case (req_cmd)
      CmdNop, CmdClear: has_resp = 1'b0;
      CmdRd: begin
        local_cmd = 1'b1;
        new_l1    = L1Send;
        if (cur == MesiI) begin
          new_st  = C_in ? MesiS : MesiE;
          new_bus = BusRead;
        end
      end
      CmdWr: begin
        local_cmd = 1'b1;
        new_st    = MesiM;
        new_l1    = L1Get;
        if (cur == MesiS)      new_bus = BusInv;
        else if (cur == MesiI) new_bus = BusRwim;
      end
      CmdSnpRd: begin
        if (cur == MesiM) begin
          new_st = MesiS; new_bus = BusWrite; new_l1 = L1Get; new_snp = SnpHitM;
        end else if (cur != MesiI) begin
          new_st = MesiS; new_snp = SnpHit;
        end
      end
      CmdSnpRwim: begin
        new_st = MesiI;
        if (cur == MesiM) begin
          new_bus = BusWrite; new_l1 = L1Evict; new_snp = SnpHitM;
        end else if (cur != MesiI) begin
          new_l1 = L1Inv; new_snp = SnpHit;
        end
      end
      CmdSnpInv: begin
        if (cur == MesiS) begin
          new_st = MesiI; new_l1 = L1Inv; new_snp = SnpHit;
        end
      end
      CmdSnpWr: ;
      default: ;
    endcase
    victim_dirty = local_cmd && !req_hit && (stored == MesiM);
    // Snoop misses refer to some other tag, so they must not touch the stored line.
    mem_we = accept && has_resp && (req_hit || local_cmd);
  end

  always_comb begin
    state_d    = state_q;
    clr_d      = clr_q;
    resp_d     = 1'b0;
    st_out_d   = st_out_q;
    bus_d      = BusNull;
    l1_d       = L1Null;
    snp_d      = SnpNoHit;
    pend_st_d  = pend_st_q;
    pend_bus_d = pend_bus_q;
    pend_l1_d  = pend_l1_q;
    unique case (state_q)
      StIdle, StResp: begin
        state_d = StIdle;
        if (accept) begin
          if (req_cmd == CmdClear) begin
            state_d = StClr;
            clr_d   = '0;
          end else if (has_resp) begin
            resp_d  = 1'b1;
            state_d = StResp;
            if (victim_dirty) begin
              st_out_d   = MesiI;
              bus_d      = BusWrite;
              l1_d       = L1Evict;
              pend_st_d  = new_st;
              pend_bus_d = new_bus;
              pend_l1_d  = new_l1;
              state_d    = StWb2;
            end else begin
              st_out_d = new_st;
              bus_d    = new_bus;
              l1_d     = new_l1;
              snp_d    = new_snp;
            end
          end
        end
      end
      StWb2: begin
        resp_d   = 1'b1;
        st_out_d = pend_st_q;
        bus_d    = pend_bus_q;
        l1_d     = pend_l1_q;
        state_d  = StResp;
      end
      StClr: begin
        clr_d = clr_q + 1'b1;
        if (clr_q == SW'(SETS - 1)) begin
          resp_d   = 1'b1;
          st_out_d = MesiI;
          clr_d    = '0;
          state_d  = StResp;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= StIdle;
      clr_q      <= '0;
      resp_q     <= 1'b0;
      st_out_q   <= MesiI;
      bus_q      <= BusNull;
      l1_q       <= L1Null;
      snp_q      <= SnpNoHit;
      pend_st_q  <= MesiI;
      pend_bus_q <= BusNull;
      pend_l1_q  <= L1Null;
    end else begin
      state_q    <= state_d;
      clr_q      <= clr_d;
      resp_q     <= resp_d;
      st_out_q   <= st_out_d;
      bus_q      <= bus_d;
      l1_q       <= l1_d;
      snp_q      <= snp_d;
      pend_st_q  <= pend_st_d;
      pend_bus_q <= pend_bus_d;
      pend_l1_q  <= pend_l1_d;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) mem_q[s][w] <= MesiI;
      end
    end else if (state_q == StClr) begin
      for (int w = 0; w < WAYS; w++) mem_q[clr_q][w] <= MesiI;
    end else if (mem_we) begin
      mem_q[req_set][req_way] <= new_st;
    end
  end

endmodule

// File: tb/tb_mesi_array_ctrl.sv
module tb_mesi_array_ctrl;
  localparam logic [2:0] NOP = 0, RD = 1, WR = 2, SRD = 3, SWR = 4, SRWIM = 5, SINV = 6, CLR = 7;
  localparam logic [1:0] I = 0, S = 1, E = 2, M = 3;
  localparam logic [2:0] BNUL = 0, BRD = 1, BWR = 2, BINV = 3, BRWIM = 4;
  localparam logic [2:0] LNUL = 0, LGET = 1, LSEND = 2, LINV = 3, LEVICT = 4;
  localparam logic [1:0] NOHIT = 0, HIT = 1, HITM = 2;

  logic       clk = 0, rstb = 0;
  logic       req_valid = 0, req_ready, req_hit = 0, C_in = 0;
  logic [2:0] req_cmd = 0;
  logic [3:0] req_set = 0;
  logic [1:0] req_way = 0;
  logic       resp_valid, C_out;
  logic [1:0] state_out, snoop_res;
  logic [2:0] bus_op, l1_msg;

  typedef struct {
    logic [1:0] st;
    logic [2:0] bus;
    logic [2:0] l1;
    logic [1:0] snp;
  } exp_t;
  exp_t sb[$];

  int         n_vec = 0, n_err = 0;
  logic [1:0] last_st = 0;

  mesi_array_ctrl #(.SETS(16), .WAYS(4)) dut (
    .clk(clk), .rstb(rstb), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_set(req_set), .req_way(req_way), .req_hit(req_hit),
    .C_in(C_in), .resp_valid(resp_valid), .state_out(state_out), .bus_op(bus_op),
    .l1_msg(l1_msg), .snoop_res(snoop_res), .C_out(C_out)
  );

  always #5 clk = ~clk;

  // Scoreboard: every response beat pops one expected entry; idle cycles must be quiet.
  always @(negedge clk) begin
    exp_t e;
    if (!rstb) begin
      last_st = I;
    end else if (resp_valid) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_resp t=%0t st=%0d bus=%0d l1=%0d snp=%0d, required no response",
                 $time, state_out, bus_op, l1_msg, snoop_res);
      end else begin
        e = sb.pop_front();
        last_st = e.st;
        if ({state_out, bus_op, l1_msg, snoop_res, C_out} !==
            {e.st, e.bus, e.l1, e.snp, (e.snp != 2'd0)}) begin
          n_err++;
          $display("FAIL resp t=%0t got st=%0d bus=%0d l1=%0d snp=%0d c=%0d required st=%0d bus=%0d l1=%0d snp=%0d",
                   $time, state_out, bus_op, l1_msg, snoop_res, C_out, e.st, e.bus, e.l1, e.snp);
        end
      end
    end else begin
      n_vec++;
      if ({bus_op, l1_msg, snoop_res, C_out, state_out} !== {9'd0, last_st}) begin
        n_err++;
        $display("FAIL idle_outputs t=%0t got bus=%0d l1=%0d snp=%0d c=%0d st=%0d required 0/0/0/0/%0d",
                 $time, bus_op, l1_msg, snoop_res, C_out, state_out, last_st);
      end
    end
  end

  task automatic push(input logic [1:0] st, input logic [2:0] bus, input logic [2:0] l1,
                      input logic [1:0] snp);
    exp_t e;
    e.st = st; e.bus = bus; e.l1 = l1; e.snp = snp;
    sb.push_back(e);
  endtask

  // Drive one request and hold it across the accepting edge; returns 1 ns after that edge.
  task automatic issue(input logic [2:0] cmd, input int s, input int w, input logic hit,
                       input logic cin);
    int n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!req_ready) begin
      n_vec++; n_err++;
      $display("FAIL ready_timeout got ready=0 required 1");
    end
    req_valid = 1; req_cmd = cmd; req_set = 4'(s); req_way = 2'(w); req_hit = hit; C_in = cin;
    @(posedge clk); #1;
  endtask

  task automatic probe(input int s, input int w, input logic [1:0] st);
    push(st, BNUL, LNUL, NOHIT);
    issue(SWR, s, w, 1, 0);
  endtask

  task automatic drain();
    int n = 0;
    req_valid = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2;
    n_vec++;
    if ({req_ready, resp_valid, state_out, bus_op, l1_msg, snoop_res, C_out} !== 13'b1_0000000000_00) begin
      n_err++;
      $display("FAIL reset_outputs got ready=%0d rv=%0d st=%0d bus=%0d l1=%0d snp=%0d c=%0d required 1/0/0/0/0/0/0",
               req_ready, resp_valid, state_out, bus_op, l1_msg, snoop_res, C_out);
    end
    #20 rstb = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_local();
    push(E, BRD, LSEND, NOHIT);  issue(RD, 3, 1, 0, 0);
    push(M, BNUL, LGET, NOHIT);  issue(WR, 3, 1, 1, 0);
    push(M, BNUL, LSEND, NOHIT); issue(RD, 3, 1, 1, 0);
    drain();
  endtask

  task automatic test_snoop();
    push(S, BWR, LGET, HITM);    issue(SRD, 3, 1, 1, 0);
    push(S, BNUL, LNUL, HIT);    issue(SRD, 3, 1, 1, 0);
    push(M, BINV, LGET, NOHIT);  issue(WR, 3, 1, 1, 0);
    push(I, BWR, LEVICT, HITM);  issue(SRWIM, 3, 1, 1, 0);
    push(I, BNUL, LNUL, NOHIT);  issue(SRD, 5, 2, 0, 0);
    push(E, BRD, LSEND, NOHIT);  issue(RD, 3, 1, 0, 0);
    push(E, BNUL, LNUL, NOHIT);  issue(SINV, 3, 1, 1, 0);
    push(I, BNUL, LINV, HIT);    issue(SRWIM, 3, 1, 1, 0);
    push(S, BRD, LSEND, NOHIT);  issue(RD, 3, 1, 0, 1);
    push(I, BNUL, LINV, HIT);    issue(SINV, 3, 1, 1, 0);
    push(I, BNUL, LNUL, NOHIT);  issue(SINV, 3, 1, 1, 0);
    push(M, BRWIM, LGET, NOHIT); issue(WR, 3, 1, 0, 0);
    push(M, BNUL, LNUL, NOHIT);  issue(SINV, 3, 1, 1, 0);
    push(I, BNUL, LNUL, NOHIT);  issue(SRD, 3, 1, 0, 0);  // tag miss: stored M untouched
    probe(3, 1, M);
    drain();
  endtask

  task automatic test_victim();
    push(I, BWR, LEVICT, NOHIT);
    push(S, BRD, LSEND, NOHIT);
    issue(RD, 3, 1, 0, 1);
    req_valid = 0;
    n_vec++;
    if (req_ready !== 1'b0) begin
      n_err++; $display("FAIL wb2_ready got %0d required 0", req_ready);
    end
    @(posedge clk); #1;
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++; $display("FAIL after_wb2_ready got %0d required 1", req_ready);
    end
    probe(3, 1, S);
    push(M, BRWIM, LGET, NOHIT); issue(WR, 5, 2, 0, 0);
    push(I, BWR, LEVICT, NOHIT);
    push(M, BRWIM, LGET, NOHIT);
    issue(WR, 5, 2, 0, 0);
    probe(5, 2, M);  // issued back-to-back behind the WB2 beat
    drain();
  endtask

  task automatic test_back_to_back();
    push(S, BRD, LSEND, NOHIT);  issue(RD, 7, 0, 0, 1);
    push(I, BNUL, LINV, HIT);    issue(SINV, 7, 0, 1, 0);
    push(M, BRWIM, LGET, NOHIT); issue(WR, 7, 0, 0, 0);
    probe(7, 0, M);
    drain();
  endtask

  task automatic test_nop();
    issue(NOP, 7, 0, 1, 0);
    req_valid = 0;
    repeat (3) begin @(posedge clk); #1; end
    probe(7, 0, M);
    drain();
  endtask

  task automatic test_clear();
    int cnt = 0;
    push(E, BRD, LSEND, NOHIT);  issue(RD, 0, 0, 0, 0);
    push(M, BRWIM, LGET, NOHIT); issue(WR, 15, 3, 0, 0);
    drain();
    push(I, BNUL, LNUL, NOHIT);
    issue(CLR, 0, 0, 0, 0);
    req_valid = 0;
    while (!req_ready && cnt < 40) begin
      cnt++; @(posedge clk); #1;
    end
    n_vec++;
    if (cnt != 16) begin
      n_err++; $display("FAIL clear_busy_cycles got %0d required 16", cnt);
    end
    for (int s = 0; s < 16; s++) begin
      for (int w = 0; w < 4; w++) probe(s, w, I);
    end
    drain();
  endtask

  task automatic test_clear_reset();
    int low = 0;
    push(E, BRD, LSEND, NOHIT); issue(RD, 9, 3, 0, 0);
    drain();
    issue(CLR, 0, 0, 0, 0);
    req_valid = 0;
    repeat (5) begin @(posedge clk); #1; end
    n_vec++;
    if (req_ready !== 1'b0) begin
      n_err++; $display("FAIL clr_ready got %0d required 0", req_ready);
    end
    rstb = 0;
    #3;
    n_vec++;
    if ({req_ready, resp_valid} !== 2'b10) begin
      n_err++; $display("FAIL async_reset got ready=%0d rv=%0d required 1/0", req_ready, resp_valid);
    end
    @(posedge clk); #2 rstb = 1;
    repeat (25) begin
      @(posedge clk); #1;
      if (!req_ready) low++;
    end
    n_vec++;
    if (low != 0) begin
      n_err++; $display("FAIL ready_after_abort got %0d low cycles required 0", low);
    end
    probe(9, 3, I);
    drain();
  endtask

  initial begin
    test_reset();
    test_local();
    test_snoop();
    test_victim();
    test_back_to_back();
    test_nop();
    test_clear();
    test_clear_reset();
    n_vec++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL missing_resp got %0d outstanding required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
